// File: rtl/dmem_burst_port_if.sv
`default_nettype none
// ============================================================================
// Module   : dmem_burst_port_if
// Brief    : CPU data port plus host burst-stream port of the data memory.
// Revision : 1.0 - initial release
// ============================================================================
interface dmem_burst_port_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int LEN_W  = 8
);
  logic [ADDR_W-1:0] cpu_addr;
  logic              cpu_we;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_stall;

  logic              dbg_start;
  logic              dbg_write;
  logic [ADDR_W-1:0] dbg_base;
  logic [LEN_W-1:0]  dbg_len;
  logic [DATA_W-1:0] dbg_wdata;
  logic              dbg_wvalid;
  logic              dbg_wready;
  logic [DATA_W-1:0] dbg_rdata;
  logic              dbg_rvalid;
  logic              dbg_rready;
  logic              dbg_busy;
  logic              dbg_done;

  modport slave (
    input  cpu_addr, cpu_we, cpu_wdata,
    output cpu_rdata, cpu_stall,
    input  dbg_start, dbg_write, dbg_base, dbg_len, dbg_wdata, dbg_wvalid, dbg_rready,
    output dbg_wready, dbg_rdata, dbg_rvalid, dbg_busy, dbg_done
  );

  modport master (
    output cpu_addr, cpu_we, cpu_wdata,
    input  cpu_rdata, cpu_stall,
    output dbg_start, dbg_write, dbg_base, dbg_len, dbg_wdata, dbg_wvalid, dbg_rready,
    input  dbg_wready, dbg_rdata, dbg_rvalid, dbg_busy, dbg_done
  );
endinterface
`default_nettype wire

// File: rtl/dmem_burst_port.sv
`default_nettype none
// ============================================================================
// Module   : dmem_burst_port
// Brief    : CPU data memory with a valid/ready burst engine for host load/dump.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_burst_port #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int LEN_W  = 8
) (
  input  wire logic           clk,
  input  wire logic           reset,
  dmem_burst_port_if.slave    bus
);
  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_DUMP   = 2'd2,
    S_FINISH = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rvalid_q, rvalid_d;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] ptr_inc;
  logic              stall;
  logic              load_beat;
  logic              last_beat;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  assign ptr_inc   = ptr_q + ADDR_W'(1);
  assign stall     = (state_q != S_IDLE);
  assign load_beat = (state_q == S_LOAD) && bus.dbg_wvalid;
  assign last_beat = (cnt_q == LEN_W'(1));

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    rdata_d  = rdata_q;
    rvalid_d = rvalid_q;
    case (state_q)
      S_IDLE: begin
        if (bus.dbg_start) begin
          ptr_d    = bus.dbg_base;
          cnt_d    = bus.dbg_len;
          rvalid_d = 1'b0;
          if (bus.dbg_len == '0)
            state_d = S_FINISH;
          else if (bus.dbg_write)
            state_d = S_LOAD;
          else
            state_d = S_DUMP;
        end
      end
      S_LOAD: begin
        if (load_beat) begin
          ptr_d = ptr_inc;
          cnt_d = cnt_q - LEN_W'(1);
          if (last_beat)
            state_d = S_FINISH;
        end
      end
      S_DUMP: begin
        // Output register is refilled straight from the array, so a word
        // follows every accepted handshake without a bubble.
        if (!rvalid_q) begin
          rdata_d  = mem[ptr_q];
          rvalid_d = 1'b1;
        end else if (bus.dbg_rready) begin
          ptr_d = ptr_inc;
          cnt_d = cnt_q - LEN_W'(1);
          if (last_beat) begin
            rvalid_d = 1'b0;
            state_d  = S_FINISH;
          end else begin
            rdata_d  = mem[ptr_inc];
            rvalid_d = 1'b1;
          end
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      ptr_q    <= '0;
      cnt_q    <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

  // Single write port: the engine only writes while the CPU is stalled.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = bus.cpu_addr;
    mem_wdata = bus.cpu_wdata;
    if (load_beat) begin
      mem_we    = 1'b1;
      mem_waddr = ptr_q;
      mem_wdata = bus.dbg_wdata;
    end else if (bus.cpu_we && !stall) begin
      mem_we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we)
      mem[mem_waddr] <= mem_wdata;
  end

  assign bus.cpu_rdata  = mem[bus.cpu_addr];
  assign bus.cpu_stall  = stall;
  assign bus.dbg_busy   = stall;
  assign bus.dbg_done   = (state_q == S_FINISH);
  assign bus.dbg_wready = (state_q == S_LOAD);
  assign bus.dbg_rdata  = rdata_q;
  assign bus.dbg_rvalid = rvalid_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_burst_port.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_burst_port
// Brief    : Randomised directed bench for dmem_burst_port with an array model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_burst_port;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 8;
  localparam int LEN_W  = 8;
  localparam int DEPTH  = 256;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dmem_burst_port_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) bus_if ();

  dmem_burst_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  logic [7:0] model [DEPTH];
  logic [7:0] pend  [$];
  int n_asrt = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus_if.cpu_addr   = '0;
    bus_if.cpu_we     = 1'b0;
    bus_if.cpu_wdata  = '0;
    bus_if.dbg_start  = 1'b0;
    bus_if.dbg_write  = 1'b0;
    bus_if.dbg_base   = '0;
    bus_if.dbg_len    = '0;
    bus_if.dbg_wdata  = '0;
    bus_if.dbg_wvalid = 1'b0;
    bus_if.dbg_rready = 1'b0;
  endtask

  task automatic cpu_write(input logic [7:0] a, input logic [7:0] d);
    bus_if.cpu_addr  = a;
    bus_if.cpu_wdata = d;
    bus_if.cpu_we    = 1'b1;
    tick();
    bus_if.cpu_we = 1'b0;
    model[a] = d;
  endtask

  task automatic cpu_read_chk(input string tag, input logic [7:0] a, input logic [7:0] exp);
    bus_if.cpu_addr = a;
    #1;
    chk(tag, bus_if.cpu_rdata, exp);
  endtask

  task automatic start_burst(input logic wr, input logic [7:0] base, input logic [7:0] len);
    bus_if.dbg_start = 1'b1;
    bus_if.dbg_write = wr;
    bus_if.dbg_base  = base;
    bus_if.dbg_len   = len;
    tick();
    bus_if.dbg_start = 1'b0;
    bus_if.cpu_we    = 1'b0;
  endtask

  task automatic cpu_noise(input bit en);
    if (en) begin
      bus_if.cpu_we    = 1'($urandom_range(0, 1));
      bus_if.cpu_addr  = 8'($urandom);
      bus_if.cpu_wdata = 8'($urandom);
    end
  endtask

  task automatic post_burst_chk();
    tick();
    bus_if.cpu_we = 1'b0;
    chk("done_after", bus_if.dbg_done, 0);
    chk("busy_after", bus_if.dbg_busy, 0);
    chk("stall_after", bus_if.cpu_stall, 0);
  endtask

  // vmode 0: wvalid held high, 1: random wvalid
  task automatic run_load(input logic [7:0] base, input logic [7:0] len, input int vmode, input bit noise);
    int beats = 0;
    bit seen = 0;
    logic [7:0] a;
    start_burst(1'b1, base, len);
    for (int cyc = 0; cyc < 4000 && !seen; cyc++) begin
      chk("load_busy", bus_if.dbg_busy, 1);
      chk("load_stall", bus_if.cpu_stall, 1);
      cpu_noise(noise);
      if (bus_if.dbg_done) begin
        seen = 1;
        chk("load_wready_finish", bus_if.dbg_wready, 0);
      end else begin
        if (beats < int'(len)) begin
          chk("load_wready", bus_if.dbg_wready, 1);
          bus_if.dbg_wvalid = (vmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
          if (bus_if.dbg_wvalid && pend.size() > 0) bus_if.dbg_wdata = pend.pop_front();
          else bus_if.dbg_wdata = 8'($urandom);
        end else begin
          bus_if.dbg_wvalid = 1'b0;
          chk("load_wready_after_last", bus_if.dbg_wready, 0);
        end
        if (bus_if.dbg_wvalid && bus_if.dbg_wready) begin
          a = base + 8'(beats);
          model[a] = bus_if.dbg_wdata;
          beats++;
        end
        tick();
      end
    end
    bus_if.dbg_wvalid = 1'b0;
    chk("load_done_seen", seen, 1);
    chk("load_beats", beats, len);
    post_burst_chk();
  endtask

  // rmode 0: rready held high, 1: toggling 1,0,..., 2: random
  task automatic run_dump(input logic [7:0] base, input logic [7:0] len, input int rmode, input bit noise);
    int k = 0;
    bit seen = 0;
    bit held = 0;
    bit tog = 1;
    logic [7:0] hd = '0;
    logic [7:0] a;
    start_burst(1'b0, base, len);
    for (int cyc = 0; cyc < 4000 && !seen; cyc++) begin
      chk("dump_busy", bus_if.dbg_busy, 1);
      cpu_noise(noise);
      if (bus_if.dbg_done) begin
        seen = 1;
        chk("dump_rvalid_finish", bus_if.dbg_rvalid, 0);
      end else begin
        if (cyc == 0) chk("dump_first_latency", bus_if.dbg_rvalid, 0);
        if (cyc == 1) chk("dump_first_valid", bus_if.dbg_rvalid, 1);
        if (rmode == 0 && cyc >= 1) chk("dump_stream", bus_if.dbg_rvalid, 1);
        if (held) begin
          chk("dump_hold_valid", bus_if.dbg_rvalid, 1);
          chk("dump_hold_data", bus_if.dbg_rdata, hd);
        end
        bus_if.dbg_rready = (rmode == 0) ? 1'b1 : (rmode == 1) ? tog : 1'($urandom_range(0, 1));
        tog = ~tog;
        if (bus_if.dbg_rvalid && bus_if.dbg_rready) begin
          a = base + 8'(k);
          chk("dump_data", bus_if.dbg_rdata, model[a]);
          k++;
        end
        held = bus_if.dbg_rvalid && !bus_if.dbg_rready;
        hd   = bus_if.dbg_rdata;
        tick();
      end
    end
    bus_if.dbg_rready = 1'b0;
    chk("dump_done_seen", seen, 1);
    chk("dump_words", k, len);
    post_burst_chk();
  endtask

  initial begin
    logic [7:0] a;
    reset = 1'b0;
    idle_inputs();
    #12;
    chk("rst_stall", bus_if.cpu_stall, 0);
    chk("rst_wready", bus_if.dbg_wready, 0);
    chk("rst_rvalid", bus_if.dbg_rvalid, 0);
    chk("rst_busy", bus_if.dbg_busy, 0);
    chk("rst_done", bus_if.dbg_done, 0);
    chk("rst_rdata", bus_if.dbg_rdata, 0);
    tick();
    reset = 1'b1;
    tick();

    for (int i = 0; i < DEPTH; i++) cpu_write(8'(i), 8'($urandom));

    // Load fixed operands; a CPU write in the start cycle must land.
    pend = '{8'hF0, 8'hCC, 8'h00, 8'hC3, 8'h55};
    bus_if.cpu_we    = 1'b1;
    bus_if.cpu_addr  = 8'h80;
    bus_if.cpu_wdata = 8'h5A;
    model[8'h80] = 8'h5A;
    run_load(8'h00, 8'd5, 0, 1'b0);
    cpu_read_chk("start_cycle_cpu_write", 8'h80, 8'h5A);
    run_dump(8'h00, 8'd5, 0, 1'b0);

    cpu_write(8'h02, 8'hF0 ^ 8'hCC);
    cpu_write(8'h05, 8'hC3 & 8'h55);
    cpu_read_chk("cpu_xor", 8'h02, 8'h3C);
    cpu_read_chk("cpu_and", 8'h05, 8'h41);
    run_dump(8'h00, 8'd6, 0, 1'b1);

    // Address wrap
    pend = '{8'h01, 8'h02, 8'h03, 8'h04};
    run_load(8'hFE, 8'd4, 0, 1'b1);
    cpu_read_chk("wrap_fe", 8'hFE, 8'h01);
    cpu_read_chk("wrap_ff", 8'hFF, 8'h02);
    cpu_read_chk("wrap_00", 8'h00, 8'h03);
    cpu_read_chk("wrap_01", 8'h01, 8'h04);
    run_dump(8'hFC, 8'd8, 2, 1'b0);

    run_dump(8'h40, 8'd4, 1, 1'b0);

    // Empty bursts, with CPU writes attempted during FINISH
    run_load(8'h30, 8'd0, 0, 1'b1);
    run_dump(8'h30, 8'd0, 0, 1'b1);

    for (int i = 0; i < 8; i++) begin
      a = 8'($urandom);
      if ($urandom_range(0, 1) == 1) run_load(a, 8'($urandom_range(1, 40)), int'($urandom_range(0, 1)), 1'b1);
      else run_dump(a, 8'($urandom_range(1, 40)), int'($urandom_range(0, 2)), 1'b1);
    end

    // Reset after 4 of 10 load beats
    start_burst(1'b1, 8'h10, 8'd10);
    for (int i = 0; i < 4; i++) begin
      chk("abort_wready", bus_if.dbg_wready, 1);
      bus_if.dbg_wvalid = 1'b1;
      bus_if.dbg_wdata  = 8'($urandom);
      a = 8'h10 + 8'(i);
      model[a] = bus_if.dbg_wdata;
      tick();
    end
    reset = 1'b0;
    bus_if.dbg_wvalid = 1'b0;
    #1;
    chk("abort_stall", bus_if.cpu_stall, 0);
    chk("abort_wready_rst", bus_if.dbg_wready, 0);
    chk("abort_rvalid", bus_if.dbg_rvalid, 0);
    chk("abort_busy", bus_if.dbg_busy, 0);
    chk("abort_done", bus_if.dbg_done, 0);
    chk("abort_rdata", bus_if.dbg_rdata, 0);
    tick();
    tick();
    reset = 1'b1;
    tick();
    run_dump(8'h10, 8'd10, 0, 1'b0);
    run_load(8'h20, 8'd3, 1, 1'b0);

    for (int i = 0; i < DEPTH; i++) cpu_read_chk("final_mem", 8'(i), model[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
